aud_capture: RTL and testbench

AUD_CAPTURE -- requirements
Module: aud_capture

---
 rtl/aud_capture.sv | 151 +++++++++++++++
 tb/tb_aud_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_capture.sv
// I2S left-channel audio capture into word-addressed SRAM.
// Codec lines are synchronized into i_clk; one sample is written per left frame.
module aud_capture #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(20'hFFFFF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_full,
  output logic [2:0]        o_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_LRC = 3'd1,
    S_SKIP     = 3'd2,
    S_SHIFT    = 3'd3,
    S_WRITE    = 3'd4,
    S_PAUSED   = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [1:0]        bclk_sync, lrc_sync, dat_sync;
  logic              bclk_d, lrc_d;
  logic              bclk_rise, lrc_fall, dat_bit;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              full_r;

  logic clr_addr, cnt_clr, shift_en, load_out, do_write;

  // Two flops per codec line, then a delayed copy for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
      lrc_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the chain really is N stages deep.
      bclk_sync <= {bclk_sync[0], i_AUD_BCLK};
      lrc_sync  <= {lrc_sync[0], i_AUD_ADCLRCK};
      dat_sync  <= {dat_sync[0], i_AUD_ADCDAT};
      bclk_d    <= bclk_sync[1];
      lrc_d     <= lrc_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;
  assign lrc_fall  = ~lrc_sync[1] & lrc_d;
  assign dat_bit   = dat_sync[1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_n  = state;
    clr_addr = 1'b0;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    load_out = 1'b0;
    do_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_n  = S_WAIT_LRC;
          clr_addr = 1'b1;
        end
      end
      S_WAIT_LRC, S_SKIP, S_SHIFT: begin
        if (i_stop)       state_n = S_IDLE;
        else if (i_pause) state_n = S_PAUSED;
        else if (state == S_WAIT_LRC) begin
          if (lrc_fall) state_n = S_SKIP;
        end else if (state == S_SKIP) begin
          if (bclk_rise) begin
            state_n = S_SHIFT;
            cnt_clr = 1'b1;
          end
        end else begin
          // A new left frame before the sample completed means we lost sync.
          if (lrc_fall) state_n = S_SKIP;
          else if (bclk_rise) begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state_n  = S_WRITE;
              load_out = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        // The write and address update always complete; commands steer only the next state.
        do_write = 1'b1;
        if (addr_r == ADDR_MAX) state_n = S_IDLE;
        else if (i_stop)        state_n = S_IDLE;
        else if (i_pause)       state_n = S_PAUSED;
        else                    state_n = S_WAIT_LRC;
      end
      S_PAUSED: begin
        if (i_stop)       state_n = S_IDLE;
        else if (i_start) state_n = S_WAIT_LRC;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      data_r <= '0;
      addr_r <= '0;
      full_r <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (shift_en) shreg  <= {shreg[DATA_W-2:0], dat_bit};
      if (load_out) data_r <= {shreg[DATA_W-2:0], dat_bit};
      if (clr_addr) begin
        addr_r <= '0;
        full_r <= 1'b0;
      end else if (do_write) begin
        if (addr_r == ADDR_MAX) full_r <= 1'b1;
        else                    addr_r <= addr_r + 1'b1;
      end
    end
  end

  assign o_data    = data_r;
  assign o_address = addr_r;
  assign o_valid   = (state == S_WRITE);
  assign o_full    = full_r;
  assign o_state   = state;

endmodule

// File: tb/tb_aud_capture.sv
// Directed bench for aud_capture: an I2S codec model drives frames, a scoreboard
// queue holds expected writes and a negedge monitor compares every o_valid strobe.
`timescale 1ns/1ps
module tb_aud_capture;

  localparam int                DATA_W   = 16;
  localparam int                ADDR_W   = 20;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 20'd3;
  localparam int                HALF     = 24;

  logic              i_clk = 1'b0;
  logic              i_rst, i_start, i_pause, i_stop;
  logic              bclk, lrc, dat;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_address;
  logic              o_valid, o_full;
  logic [2:0]        o_state;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  aud_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_MAX(ADDR_MAX)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_stop        (i_stop),
    .i_AUD_BCLK    (bclk),
    .i_AUD_ADCLRCK (lrc),
    .i_AUD_ADCDAT  (dat),
    .o_data        (o_data),
    .o_address     (o_address),
    .o_valid       (o_valid),
    .o_full        (o_full),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'd0);
    check({tag, "_data"},  32'(o_data), 32'd0);
    check({tag, "_addr"},  32'(o_address), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_full"},  32'(o_full), 32'd0);
  endtask

  // Scoreboard side: each strobe must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid_q_size", 32'(exp_q.size()), 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_data", 32'(o_data), 32'(e.data));
        check("wr_addr", 32'(o_address), 32'(e.addr));
      end
    end
  end

  function automatic logic slot_bit(input logic [15:0] v, input int s);
    if (s >= 1 && s <= 16) return v[16-s];
    return 1'b0;
  endfunction

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // cmd = {rst, stop, pause, start}, pulsed for one clock during slot cmd_slot.
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int half,
                       input int cmd_slot, input logic [3:0] cmd);
    for (int s = 0; s < 2*half; s++) begin
      bclk = 1'b0;
      lrc  = (s >= half);
      dat  = (s < half) ? slot_bit(l, s) : slot_bit(r, s - half);
      repeat (4) @(negedge i_clk);
      bclk = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (s == cmd_slot && c == 1) {i_rst, i_stop, i_pause, i_start} = cmd;
        @(negedge i_clk);
        if (i_rst) check_idle_zero("mid_reset");
        {i_rst, i_stop, i_pause, i_start} = 4'b0;
      end
    end
  endtask

  task automatic pulse(input logic [3:0] cmd);
    {i_rst, i_stop, i_pause, i_start} = cmd;
    @(negedge i_clk);
    {i_rst, i_stop, i_pause, i_start} = 4'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_PAUSE = 4'b0010;
  localparam logic [3:0] C_STOP  = 4'b0100;
  localparam logic [3:0] C_RST   = 4'b1000;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    bclk = 1'b0; lrc = 1'b1; dat = 1'b0;
    repeat (3) @(negedge i_clk);
    check_idle_zero("reset");
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single frame capture.
    pulse(C_START);
    check("start_state", 32'(o_state), 32'd1);
    expect_wr(0, 16'hA5C3);
    frame(16'hA5C3, 16'hFFFF, HALF, -1, 4'b0);
    check_drained("single_pending");
    check("single_addr_after", 32'(o_address), 32'd1);
    check("single_state_after", 32'(o_state), 32'd1);
    pulse(C_STOP);
    check("single_stop_state", 32'(o_state), 32'd0);
    check("single_stop_addr", 32'(o_address), 32'd1);

    // Three boundary-value frames.
    pulse(C_START);
    check("restart_addr_clear", 32'(o_address), 32'd0);
    expect_wr(0, 16'h0001);
    frame(16'h0001, 16'h0000, HALF, -1, 4'b0);
    expect_wr(1, 16'h8000);
    frame(16'h8000, 16'hFFFF, HALF, -1, 4'b0);
    expect_wr(2, 16'h7FFF);
    frame(16'h7FFF, 16'h0000, HALF, -1, 4'b0);
    check_drained("three_pending");
    pulse(C_STOP);
    check("three_stop_state", 32'(o_state), 32'd0);
    check("three_stop_addr", 32'(o_address), 32'd3);
    check("three_data_hold", 32'(o_data), 32'h7FFF);

    // Pause mid-sample, then resume without clearing the address.
    pulse(C_START);
    expect_wr(0, 16'h1234);
    frame(16'h1234, 16'h0000, HALF, -1, 4'b0);
    frame(16'h5678, 16'h0000, HALF, 8, C_PAUSE);
    check_drained("pause_pending");
    check("pause_state", 32'(o_state), 32'd5);
    check("pause_addr", 32'(o_address), 32'd1);
    pulse(C_START);
    check("resume_state", 32'(o_state), 32'd1);
    check("resume_addr", 32'(o_address), 32'd1);
    expect_wr(1, 16'h9ABC);
    frame(16'h9ABC, 16'h0000, HALF, -1, 4'b0);
    check_drained("resume_pending");
    check("resume_addr_after", 32'(o_address), 32'd2);
    pulse(C_STOP);

    // Fill memory to ADDR_MAX.
    pulse(C_START);
    expect_wr(0, 16'h1111);
    frame(16'h1111, 16'h0000, HALF, -1, 4'b0);
    expect_wr(1, 16'h2222);
    frame(16'h2222, 16'h0000, HALF, -1, 4'b0);
    expect_wr(2, 16'h3333);
    frame(16'h3333, 16'h0000, HALF, -1, 4'b0);
    check("prefull_flag", 32'(o_full), 32'd0);
    expect_wr(3, 16'h4444);
    frame(16'h4444, 16'h0000, HALF, -1, 4'b0);
    check_drained("full_pending");
    check("full_flag", 32'(o_full), 32'd1);
    check("full_state", 32'(o_state), 32'd0);
    check("full_addr", 32'(o_address), 32'd3);
    frame(16'h5555, 16'h0000, HALF, -1, 4'b0);
    check_drained("full_ignored_pending");
    check("full_ignored_addr", 32'(o_address), 32'd3);
    check("full_ignored_data", 32'(o_data), 32'h4444);
    pulse(C_START);
    check("full_clear_flag", 32'(o_full), 32'd0);
    check("full_clear_addr", 32'(o_address), 32'd0);
    check("full_clear_state", 32'(o_state), 32'd1);
    pulse(C_STOP);

    // Stop and start together during SHIFT: stop wins.
    pulse(C_START);
    frame(16'hBEEF, 16'h0000, HALF, 5, C_STOP | C_START);
    check_drained("stopstart_pending");
    check("stopstart_state", 32'(o_state), 32'd0);
    check("stopstart_addr", 32'(o_address), 32'd0);

    // Reset during SHIFT aborts; capture resumes only after start.
    pulse(C_START);
    frame(16'hCAFE, 16'h0000, HALF, 6, C_RST);
    check_drained("rst_pending");
    check("rst_state_after", 32'(o_state), 32'd0);
    frame(16'hDEAD, 16'h0000, HALF, -1, 4'b0);
    check_drained("rst_idle_pending");
    pulse(C_START);
    expect_wr(0, 16'h0F0F);
    frame(16'h0F0F, 16'h0000, HALF, -1, 4'b0);
    check_drained("rst_resume_pending");
    check("rst_resume_addr", 32'(o_address), 32'd1);
    pulse(C_STOP);

    // Short frame: new left frame arrives mid-sample, capture resynchronizes.
    pulse(C_START);
    frame(16'hFFFF, 16'hFFFF, 6, -1, 4'b0);
    expect_wr(0, 16'h1357);
    frame(16'h1357, 16'h0000, HALF, -1, 4'b0);
    check_drained("resync_pending");
    check("resync_addr", 32'(o_address), 32'd1);
    pulse(C_STOP);

    repeat (4) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
